seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It holds a NUM_DIGITS-wide hex value and scans one digit at a time, driving shared active-low segment lines and one active-low digit enable per digit. New values are double-buffered and committed only at frame boundaries, so the display never tears mid-frame. It sits between the system's counters/registers and the board's display pins.

---
 rtl/seven_segment_scanner.sv | 139 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-boundary double buffering.
// Optional macro SEVSEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    enable,
  output logic                    pending,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_en_n
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;

  logic                  tc, frame_end, commit;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  lz_blank;
  logic                  lit;
  logic [NUM_DIGITS-1:0] onehot_n;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      segments_q   <= 7'h7F;
      dp_n_q       <= 1'b1;
      digit_en_n_q <= '1;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      segments_q   <= segments_d;
      dp_n_q       <= dp_n_d;
      digit_en_n_q <= digit_en_n_d;
    end
  end

  // A load coinciding with a commit refills the pending buffer after the old contents move over.
  always_comb begin
    tc        = (div_q == DIV_LAST);
    frame_end = tc && (idx_q == IDX_LAST);
    commit    = frame_end && pending_q;
    div_d     = tc ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    act_val_d  = commit ? pend_val_q : act_val_q;
    act_dp_d   = commit ? pend_dp_q : act_dp_q;
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp : pend_dp_q;
    pending_d  = load | (pending_q & ~commit);
  end

  always_comb begin
    nib      = 4'h0;
    dp_sel   = 1'b0;
    onehot_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib         = act_val_q[4*i +: 4];
        dp_sel      = act_dp_q[i];
        onehot_n[i] = 1'b0;
      end
    end
  end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  always_comb begin : lz_calc
    logic hi_zero;
    hi_zero  = 1'b1;
    lz_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && (act_val_q[4*i +: 4] == 4'h0);
      if ((idx_q == IDX_W'(i)) && hi_zero) lz_blank = 1'b1;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    lit          = enable && (div_q >= BLANK_LIM);
    segments_d   = 7'h7F;
    dp_n_d       = 1'b1;
    digit_en_n_d = '1;
    if (lit) begin
      segments_d   = lz_blank ? 7'h7F : seg_decode(nib);
      dp_n_d       = ~dp_sel;
      digit_en_n_d = onehot_n;
    end
  end

  assign pending    = pending_q;
  assign segments   = segments_q;
  assign dp_n       = dp_n_q;
  assign digit_en_n = digit_en_n_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a cycle-count reference model predicts every registered output.
module tb_seven_segment_scanner;
  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = ND * CD;
  localparam logic [6:0] DECODE_TAB [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        pending;
  logic [6:0]  segments;
  logic        dp_n;
  logic [3:0]  digit_en_n;

  seven_segment_scanner #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load), .enable(enable),
    .pending(pending), .segments(segments), .dp_n(dp_n), .digit_en_n(digit_en_n));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dpn;
    logic [3:0] en;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Model state: t is the cycle index since reset release.
  int          t = 0;
  logic [15:0] m_act = '0, m_pbuf = '0;
  logic [3:0]  m_act_dp = '0, m_pdp = '0;
  bit          m_pflag = 0;

  always @(posedge clk) begin : model
    int   slot, pos;
    exp_t e;
    bit   commit;
    if (!rst_n) begin
      t = 0; m_act = '0; m_pbuf = '0; m_act_dp = '0; m_pdp = '0; m_pflag = 0;
      exp_q.delete();
    end else begin
      slot = (t / CD) % ND;
      pos  = t % CD;
      e.seg = 7'h7F; e.dpn = 1'b1; e.en = 4'hF;
      if (enable && pos >= BC) begin
        e.en  = ~(4'b0001 << slot);
        e.seg = DECODE_TAB[m_act[4*slot +: 4]];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (slot != 0 && (m_act >> (4*slot)) == 16'h0) e.seg = 7'h7F;
`endif
        e.dpn = !m_act_dp[slot];
      end
      commit = ((t % FRAME) == FRAME - 1) && m_pflag;
      if (commit) begin m_act = m_pbuf; m_act_dp = m_pdp; end
      if (load) begin m_pbuf = value; m_pdp = dp; m_pflag = 1; end
      else if (commit) m_pflag = 0;
      e.pend = m_pflag;
      exp_q.push_back(e);
      t++;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t g;
    if (rst_n && exp_q.size() > 0) begin
      g = exp_q.pop_front();
      checks++;
      if ({segments, dp_n, digit_en_n, pending} !== g) begin
        failures++;
        $display("FAIL scoreboard @%0t got seg=%h dpn=%b en=%h pend=%b need seg=%h dpn=%b en=%h pend=%b",
                 $time, segments, dp_n, digit_en_n, pending, g.seg, g.dpn, g.en, g.pend);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h need=%h", name, got, want);
    end
  endtask

  task automatic wait_digit(input int d, input logic [6:0] seg, input string name);
    bit found = 0;
    for (int k = 0; k < 3*FRAME && !found; k++) begin
      @(negedge clk);
      if (digit_en_n == ~(4'b0001 << d)) found = 1;
    end
    check({name, "_seen"}, 16'(found), 16'd1);
    if (found) check(name, 16'(segments), 16'(seg));
  endtask

  task automatic wait_phase(input int ph, input string name);
    bit hit = 0;
    for (int k = 0; k < FRAME + 2 && !hit; k++) begin
      if ((t % FRAME) == ph) hit = 1;
      else @(negedge clk);
    end
    check({name, "_phase"}, 16'(hit), 16'd1);
  endtask

  task automatic wait_commit(input string name);
    bit done = 0;
    for (int k = 0; k < 2*FRAME && !done; k++) begin
      @(negedge clk);
      if (!pending) done = 1;
    end
    check({name, "_commit"}, 16'(done), 16'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_seg", 16'(segments), 16'h7F);
    check("rst_dpn", 16'(dp_n), 16'h1);
    check("rst_en", 16'(digit_en_n), 16'hF);
    check("rst_pend", 16'(pending), 16'h0);
    #1 rst_n = 1'b1;
    wait_digit(0, 7'h40, "rst_digit0");
    check("rst_digit0_en", 16'(digit_en_n), 16'hE);

    do_load(16'h12AF, 4'h0);
    repeat (2*FRAME) @(negedge clk);
    wait_digit(0, 7'h0E, "scan_d0");
    wait_digit(1, 7'h08, "scan_d1");
    wait_digit(2, 7'h24, "scan_d2");
    wait_digit(3, 7'h79, "scan_d3");

    wait_phase(6, "dbuf");
    do_load(16'h1234, 4'h0);
    check("dbuf_pend", 16'(pending), 16'h1);
    wait_digit(1, 7'h08, "dbuf_old");
    wait_commit("dbuf");
    wait_digit(1, 7'h30, "dbuf_new");

    wait_phase(2, "simul_a");
    do_load(16'h5555, 4'h0);
    wait_phase(FRAME - 1, "simul_b");
    do_load(16'h9999, 4'h0);
    check("simul_pend", 16'(pending), 16'h1);
    wait_digit(0, 7'h12, "simul_5555_d0");
    wait_digit(3, 7'h12, "simul_5555_d3");
    wait_digit(0, 7'h10, "simul_9999_d0");

    do_load(16'h4321, 4'b0100);
    wait_commit("dp");
    wait_digit(2, 7'h30, "dp_d2");
    check("dp_d2_dpn", 16'(dp_n), 16'h0);
    wait_digit(1, 7'h24, "dp_d1");
    check("dp_d1_dpn", 16'(dp_n), 16'h1);
    enable = 1'b0;
    @(negedge clk);
    check("en_off_seg", 16'(segments), 16'h7F);
    check("en_off_en", 16'(digit_en_n), 16'hF);
    repeat (10) @(negedge clk);
    enable = 1'b1;

    do_load(16'h0070, 4'h0);
    wait_commit("lz");
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    wait_digit(3, 7'h7F, "lz_d3");
    wait_digit(2, 7'h7F, "lz_d2");
`else
    wait_digit(3, 7'h40, "lz_d3");
    wait_digit(2, 7'h40, "lz_d2");
`endif
    wait_digit(1, 7'h78, "lz_d1");
    wait_digit(0, 7'h40, "lz_d0");

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 200) begin
        load = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_seg", 16'(segments), 16'h7F);
        check("midrst_dpn", 16'(dp_n), 16'h1);
        check("midrst_en", 16'(digit_en_n), 16'hF);
        check("midrst_pend", 16'(pending), 16'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
      end else begin
        load  = ($urandom_range(0, 7) == 0);
        value = 16'($urandom);
        dp    = 4'($urandom);
        if ($urandom_range(0, 15) == 0) enable = ~enable;
      end
    end
    load = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
